// File: rtl/alu_issue.sv
// alu_issue: single-outstanding issue stage in front of a combinational ALU.
// A request is latched in IDLE, its operands are held on registered ALU
// inputs for one cycle (or MULDIV_WAIT cycles for mul/div), the ALU result
// is captured, and the response is held until the consumer takes it.
// Divide-by-zero never reaches the ALU; it is answered directly with an error.
module alu_issue #(
   parameter int DATA_WIDTH  = 16,
   parameter int MULDIV_WAIT = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   input  logic [2:0]            req_op,
   input  logic [3:0]            req_rd,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [2:0]            alu_op,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_zero,
   output logic [3:0]            rsp_rd,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   // Down-counter load value: the last EXEC cycle is the one where the count is zero.
   localparam logic [3:0] WAIT_LOAD = 4'(MULDIV_WAIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                state_reg;
   logic [3:0]            cnt_reg;
   logic [DATA_WIDTH-1:0] alu_a_reg;
   logic [DATA_WIDTH-1:0] alu_b_reg;
   logic [2:0]            alu_op_reg;
   logic [DATA_WIDTH-1:0] rsp_result_reg;
   logic                  rsp_zero_reg;
   logic [3:0]            rsp_rd_reg;
   logic                  rsp_err_reg;

   // Handshake and status flags are pure decodes of the state register.
   assign req_ready  = (state_reg == ST_IDLE);
   assign rsp_valid  = (state_reg == ST_RESP);
   assign busy       = (state_reg != ST_IDLE);

   assign alu_a      = alu_a_reg;
   assign alu_b      = alu_b_reg;
   assign alu_op     = alu_op_reg;
   assign rsp_result = rsp_result_reg;
   assign rsp_zero   = rsp_zero_reg;
   assign rsp_rd     = rsp_rd_reg;
   assign rsp_err    = rsp_err_reg;

   // Issue FSM: accept in IDLE, hold ALU inputs through EXEC, present response in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= 4'd0;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
         alu_op_reg     <= OP_NOP;
         rsp_result_reg <= '0;
         rsp_zero_reg   <= 1'b0;
         rsp_rd_reg     <= 4'd0;
         rsp_err_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               // req_ready is high in IDLE, so req_valid alone means accept.
               if (req_valid) begin
                  rsp_rd_reg <= req_rd;
                  if (req_op == OP_DIV && req_b == '0) begin
                     // Answer divide-by-zero without touching the ALU.
                     rsp_result_reg <= '0;
                     rsp_zero_reg   <= 1'b1;
                     rsp_err_reg    <= 1'b1;
                     cnt_reg        <= 4'd0;
                     state_reg      <= ST_RESP;
                  end else begin
                     alu_a_reg   <= req_a;
                     alu_b_reg   <= req_b;
                     alu_op_reg  <= req_op;
                     rsp_err_reg <= 1'b0;
                     cnt_reg     <= (req_op == OP_MUL || req_op == OP_DIV) ? WAIT_LOAD : 4'd0;
                     state_reg   <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               if (cnt_reg == 4'd0) begin
                  rsp_result_reg <= alu_result;
                  rsp_zero_reg   <= alu_zero;
                  alu_op_reg     <= OP_NOP;
                  state_reg      <= ST_RESP;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg  <= ST_IDLE;
               alu_op_reg <= OP_NOP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue. A behavioural ALU sits on
// the alu_* port, expected responses are queued at the accepting edge and a
// monitor pops/compares them on every response handshake.
// Latency is counted as clock edges from the accepting edge to the edge
// after which rsp_valid is first seen: 1 for single-cycle ops, MULDIV_WAIT
// for mul/div, and 0 for divide-by-zero, which goes straight to RESP.
module tb_alu_issue;

   localparam int DW = 16;
   localparam int MW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [DW-1:0] req_a = '0;
   logic [DW-1:0] req_b = '0;
   logic [2:0]    req_op = 3'd0;
   logic [3:0]    req_rd = 4'd0;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [2:0]    alu_op;
   logic [DW-1:0] alu_result;
   logic          alu_zero;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_result;
   logic          rsp_zero;
   logic [3:0]    rsp_rd;
   logic          rsp_err;
   logic          busy;

   int n_vec = 0;
   int n_miscmp = 0;

   typedef struct packed {
      logic [DW-1:0] res;
      logic          zero;
      logic [3:0]    rd;
      logic          err;
   } rsp_t;

   rsp_t sb[$];

   always #5 clk = ~clk;

   alu_issue #(.DATA_WIDTH(DW), .MULDIV_WAIT(MW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .req_rd     (req_rd),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_rd     (rsp_rd),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   // Behavioural ALU driven by the DUT's registered operand outputs.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         3'b000: alu_result = alu_a + alu_b;
         3'b001: alu_result = alu_a ^ alu_b;
         3'b010: alu_result = alu_b;
         3'b011: alu_result = alu_a - alu_b;
         3'b100: alu_result = alu_a & alu_b;
         3'b101: alu_result = alu_a * alu_b;
         3'b110: alu_result = (alu_b == '0) ? '0 : alu_a / alu_b;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic rsp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [2:0] op, input logic [3:0] rd);
      rsp_t r;
      r.rd  = rd;
      r.err = 1'b0;
      r.res = '0;
      case (op)
         3'b000: r.res = a + b;
         3'b001: r.res = a ^ b;
         3'b010: r.res = b;
         3'b011: r.res = a - b;
         3'b100: r.res = a & b;
         3'b101: r.res = a * b;
         3'b110: if (b == '0) r.err = 1'b1; else r.res = a / b;
         default: r.res = '0;
      endcase
      r.zero = (r.res == '0);
      return r;
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [DW-1:0] b);
      if (op == 3'b110 && b == '0) return 0;
      if (op == 3'b101 || op == 3'b110) return MW;
      return 1;
   endfunction

   // Response monitor: every completed handshake must match the oldest queued entry.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check("spurious_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            check("rsp_rd", 32'(rsp_rd), 32'(e.rd));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            $display("rsp rd=%0d result=0x%04h zero=%0b err=%0b", rsp_rd, rsp_result, rsp_zero, rsp_err);
         end
      end
   end

   // Drive one request as soon as req_ready is seen; returns just after the accepting edge.
   task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [2:0] op, input logic [3:0] rd, input bit expect_rsp);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("issue_ready", 32'(req_ready), 32'd1);
      req_a = a; req_b = b; req_op = op; req_rd = rd; req_valid = 1'b1;
      @(posedge clk);
      if (expect_rsp) sb.push_back(model(a, b, op, rd));
      $display("req a=0x%04h b=0x%04h op=%0d rd=%0d", a, b, op, rd);
      #1 req_valid = 1'b0;
   endtask

   // Wait for rsp_valid, checking the held ALU op and req_ready on each EXEC cycle.
   task automatic wait_rsp(input logic [2:0] op_exp, output int lat);
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = k;
            break;
         end
         check("exec_alu_op", 32'(alu_op), 32'(op_exp));
         check("exec_req_ready", 32'(req_ready), 32'd0);
      end
   endtask

   logic [DW-1:0] ta [8] = '{16'h0005, 16'h0010, 16'h0009, 16'hF0F0, 16'hAAAA, 16'hFF00, 16'd100, 16'h1234};
   logic [DW-1:0] tb [8] = '{16'h0003, 16'h0003, 16'h0000, 16'h0FF0, 16'h5555, 16'h0F0F, 16'd7,   16'h5678};
   logic [2:0]    top[8] = '{3'd0, 3'd5, 3'd6, 3'd1, 3'd2, 3'd4, 3'd6, 3'd7};
   logic [3:0]    trd[8] = '{4'd4, 4'd1, 4'd3, 4'd5, 4'd6, 4'd8, 4'd10, 4'd15};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int accepts;
      int first_done;
      rsp_t e;

      // Reset values while rst_n is low.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd7);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
      check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);

      // Table of single requests with rsp_ready tied high.
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         issue(ta[i], tb[i], top[i], trd[i], 1'b1);
         wait_rsp((top[i] == 3'd6 && tb[i] == '0) ? 3'd7 : top[i], lat);
         check("latency", 32'(lat), 32'(exp_lat(top[i], tb[i])));
         check("rsp_alu_op", 32'(alu_op), 32'd7);
         if (!(top[i] == 3'd6 && tb[i] == '0)) begin
            check("hold_alu_a", 32'(alu_a), 32'(ta[i]));
            check("hold_alu_b", 32'(alu_b), 32'(tb[i]));
         end
      end

      // Sub to zero with the consumer stalling for three cycles.
      @(posedge clk); #1 rsp_ready = 1'b0;
      issue(16'h1234, 16'h1234, 3'd3, 4'd7, 1'b1);
      wait_rsp(3'd3, lat);
      check("sub_latency", 32'(lat), 32'd1);
      e = model(16'h1234, 16'h1234, 3'd3, 4'd7);
      for (int k = 0; k < 3; k++) begin
         check("stall_result", 32'(rsp_result), 32'(e.res));
         check("stall_zero", 32'(rsp_zero), 32'd1);
         check("stall_rd", 32'(rsp_rd), 32'd7);
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;

      // Reset asserted in the middle of a mul; its response must never appear.
      issue(16'h0010, 16'h0003, 3'd5, 4'd2, 1'b0);
      @(negedge clk);
      check("mid_alu_op", 32'(alu_op), 32'd5);
      check("mid_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_alu_op", 32'(alu_op), 32'd7);
      check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Back-to-back: req_valid held high across two requests.
      rsp_ready = 1'b1;
      accepts = 0;
      first_done = -1;
      @(posedge clk); #1;
      req_a = 16'h0001; req_b = 16'h0002; req_op = 3'd0; req_rd = 4'd11; req_valid = 1'b1;
      for (int k = 0; k < 40 && accepts < 2; k++) begin
         @(negedge clk);
         if (req_ready) begin
            check("b2b_busy", 32'(busy), 32'd0);
            if (accepts == 1) check("b2b_gap", 32'(k), 32'(first_done + 1));
            @(posedge clk);
            sb.push_back(model(req_a, req_b, req_op, req_rd));
            $display("req a=0x%04h b=0x%04h op=%0d rd=%0d", req_a, req_b, req_op, req_rd);
            accepts++;
            #1;
            if (accepts == 1) begin
               req_a = 16'h00FF; req_b = 16'h0F0F; req_op = 3'd4; req_rd = 4'd12;
            end else begin
               req_valid = 1'b0;
            end
         end else if (rsp_valid && accepts == 1) begin
            first_done = k;
         end
      end
      req_valid = 1'b0;
      check("b2b_accepts", 32'(accepts), 32'd2);

      repeat (6) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
